// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial-pattern detector.
package seq_det_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        HUNT    = 3'd2,
        DONE    = 3'd3,
        TIMEOUT = 3'd4
    } state_e;

    localparam logic [11:0] DEFAULT_PATTERN = 12'b1110_1101_1011;
    localparam logic [11:0] DEFAULT_MASK    = 12'hFFF;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Configuration handshake bundle between the host side and seq_det_ctrl.
interface seq_det_ctrl_if #(
    parameter int PAT_W = 12,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) ();

    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [PAT_W-1:0] cfg_pattern_i;
    logic [PAT_W-1:0] cfg_mask_i;
    logic [CNT_W-1:0] cfg_target_i;
    logic [TMO_W-1:0] cfg_tmo_i;

    modport master (
        output cfg_valid_i, cfg_pattern_i, cfg_mask_i, cfg_target_i, cfg_tmo_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i, cfg_pattern_i, cfg_mask_i, cfg_target_i, cfg_tmo_i,
        output cfg_ready_o
    );

endinterface

// File: rtl/seq_det_window.sv
// Serial shift window with a masked comparator evaluated on the post-shift value.
module seq_det_window #(
    parameter int PAT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift,
    input  logic             x_i,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    output logic             hit,
    output logic [PAT_W-1:0] window
);

    logic [PAT_W-1:0] shreg_q;
    logic [PAT_W-1:0] shreg_d;
    logic [PAT_W-1:0] next_win;

    // The incoming bit is compared in the same cycle it is shifted in.
    assign next_win = {shreg_q[PAT_W-2:0], x_i};
    assign hit      = ((next_win ^ pattern) & mask) == '0;
    assign window   = shreg_q;

    always_comb begin
        shreg_d = shreg_q;
        if (clr) begin
            shreg_d = '0;
        end else if (shift) begin
            shreg_d = next_win;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Detection controller: config capture, FILL/HUNT sequencing, match and timeout counting.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 12,
    parameter int CNT_W = 8,
    parameter int TMO_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    seq_det_ctrl_if.slave      cfg,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               x_valid_i,
    input  logic               x_i,
    output logic               det_o,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               tmo_o
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   cfg_pattern_q, cfg_mask_q;
    logic [CNT_W-1:0]   cfg_target_q;
    logic [TMO_W-1:0]   cfg_tmo_q;
    logic               cfg_loaded_q;
    logic [FILL_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               det_q, det_d;

    logic               cfg_hs;
    logic               arm;
    logic               win_clr, win_shift, win_hit;
    logic [PAT_W-1:0]   win_unused;
    logic [CNT_W-1:0]   match_inc;
    logic [TMO_W-1:0]   tmo_inc;
    logic               hit_done, tmo_expire;

    seq_det_window #(.PAT_W(PAT_W)) u_window (
        .clk     (clk),
        .reset   (reset),
        .clr     (win_clr),
        .shift   (win_shift),
        .x_i     (x_i),
        .pattern (cfg_pattern_q),
        .mask    (cfg_mask_q),
        .hit     (win_hit),
        .window  (win_unused)
    );

    assign cfg_hs     = (state_q == IDLE) && cfg.cfg_valid_i;
    assign arm        = start_i && (((state_q == IDLE) && (cfg_loaded_q || cfg_hs))
                                    || (state_q == DONE) || (state_q == TIMEOUT));
    assign match_inc  = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + 1'b1;
    assign tmo_inc    = tmo_cnt_q + 1'b1;
    assign hit_done   = (cfg_target_q != '0) && (match_inc == cfg_target_q);
    assign tmo_expire = (cfg_tmo_q != '0) && (tmo_inc == cfg_tmo_q);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        match_cnt_d = match_cnt_q;
        det_d       = 1'b0;
        win_clr     = 1'b0;
        win_shift   = 1'b0;

        if (abort_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE, TIMEOUT: begin
                    if (arm) begin
                        state_d     = FILL;
                        win_clr     = 1'b1;
                        fill_cnt_d  = '0;
                        tmo_cnt_d   = '0;
                        match_cnt_d = '0;
                    end
                end
                FILL: begin
                    if (x_valid_i) begin
                        win_shift  = 1'b1;
                        fill_cnt_d = fill_cnt_q + 1'b1;
                        // The completing bit may score a hit; a miss there does not age the timeout.
                        if (fill_cnt_q == FILL_LAST) begin
                            state_d = HUNT;
                            if (win_hit) begin
                                det_d       = 1'b1;
                                match_cnt_d = match_inc;
                                tmo_cnt_d   = '0;
                                if (hit_done) state_d = DONE;
                            end
                        end
                    end
                end
                HUNT: begin
                    if (x_valid_i) begin
                        win_shift = 1'b1;
                        if (win_hit) begin
                            det_d       = 1'b1;
                            match_cnt_d = match_inc;
                            tmo_cnt_d   = '0;
                            if (hit_done) state_d = DONE;
                        end else begin
                            tmo_cnt_d = tmo_inc;
                            if (tmo_expire) state_d = TIMEOUT;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: only control and configuration flops exist here; all get an explicit async reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fill_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            match_cnt_q   <= '0;
            det_q         <= 1'b0;
            cfg_pattern_q <= '0;
            cfg_mask_q    <= '0;
            cfg_target_q  <= '0;
            cfg_tmo_q     <= '0;
            cfg_loaded_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            match_cnt_q <= match_cnt_d;
            det_q       <= det_d;
            if (cfg_hs) begin
                cfg_pattern_q <= cfg.cfg_pattern_i;
                cfg_mask_q    <= cfg.cfg_mask_i;
                cfg_target_q  <= cfg.cfg_target_i;
                cfg_tmo_q     <= cfg.cfg_tmo_i;
                cfg_loaded_q  <= 1'b1;
            end
        end
    end

    assign cfg.cfg_ready_o = (state_q == IDLE);
    assign det_o           = det_q;
    assign match_cnt_o     = match_cnt_q;
    assign busy_o          = (state_q == FILL) || (state_q == HUNT);
    assign done_o          = (state_q == DONE);
    assign tmo_o           = (state_q == TIMEOUT);

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed and randomized checks of seq_det_ctrl against a bit-history reference model.
module tb_seq_det_ctrl;
    import seq_det_pkg::*;

    localparam int PAT_W   = 12;
    localparam int CNT_MAX = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_i = 1'b0, abort_i = 1'b0, x_valid_i = 1'b0, x_i = 1'b0;
    logic       det_o, busy_o, done_o, tmo_o;
    logic [7:0] match_cnt_o;

    seq_det_ctrl_if #(.PAT_W(12), .CNT_W(8), .TMO_W(16)) cfg_if ();

    seq_det_ctrl #(.PAT_W(12), .CNT_W(8), .TMO_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (cfg_if),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .x_valid_i   (x_valid_i),
        .x_i         (x_i),
        .det_o       (det_o),
        .match_cnt_o (match_cnt_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .tmo_o       (tmo_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: running / finished flags plus the raw history of accepted bits.
    bit          m_running, m_done, m_tmo, m_loaded, m_det;
    int          m_nbits, m_matches, m_since, m_target, m_tmo_lim;
    logic [11:0] m_pat, m_mask;
    bit          m_hist[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_running = 0; m_done = 0; m_tmo = 0; m_loaded = 0; m_det = 0;
        m_nbits = 0; m_matches = 0; m_since = 0; m_target = 0; m_tmo_lim = 0;
        m_pat = '0; m_mask = '0;
        m_hist.delete();
    endtask

    task automatic model_edge(input bit st, input bit ab, input bit cv, input bit xv, input bit xb);
        bit          idle;
        bit          hit;
        logic [11:0] w;
        idle  = !(m_running || m_done || m_tmo);
        m_det = 0;
        if (idle && cv) begin
            m_pat     = cfg_if.cfg_pattern_i;
            m_mask    = cfg_if.cfg_mask_i;
            m_target  = int'(cfg_if.cfg_target_i);
            m_tmo_lim = int'(cfg_if.cfg_tmo_i);
            m_loaded  = 1;
        end
        if (ab) begin
            m_running = 0; m_done = 0; m_tmo = 0;
        end else if (st && ((idle && m_loaded) || m_done || m_tmo)) begin
            m_running = 1; m_done = 0; m_tmo = 0;
            m_hist.delete();
            m_nbits = 0; m_matches = 0; m_since = 0;
        end else if (m_running && xv) begin
            m_hist.push_back(xb);
            if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
            m_nbits++;
            if (m_nbits >= PAT_W) begin
                w = '0;
                foreach (m_hist[i]) w = {w[10:0], m_hist[i]};
                hit = ((w ^ m_pat) & m_mask) == 12'h000;
                if (hit) begin
                    m_det = 1;
                    if (m_matches < CNT_MAX) m_matches++;
                    m_since = 0;
                    if (m_target != 0 && m_matches == m_target) begin
                        m_running = 0; m_done = 1;
                    end
                end else if (m_nbits > PAT_W) begin
                    m_since++;
                    if (m_tmo_lim != 0 && m_since == m_tmo_lim) begin
                        m_running = 0; m_tmo = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":det"},   32'(det_o),              32'(m_det));
        check({tag, ":cnt"},   32'(match_cnt_o),        32'(m_matches));
        check({tag, ":busy"},  32'(busy_o),             32'(m_running));
        check({tag, ":done"},  32'(done_o),             32'(m_done));
        check({tag, ":tmo"},   32'(tmo_o),              32'(m_tmo));
        check({tag, ":ready"}, 32'(cfg_if.cfg_ready_o), 32'(!(m_running || m_done || m_tmo)));
    endtask

    task automatic step(input bit st, input bit ab, input bit cv, input bit xv, input bit xb,
                        input string tag);
        @(negedge clk);
        start_i = st; abort_i = ab; cfg_if.cfg_valid_i = cv; x_valid_i = xv; x_i = xb;
        model_edge(st, ab, cv, xv, xb);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic set_cfg(input logic [11:0] pat, input logic [11:0] mask,
                           input logic [7:0] target, input logic [15:0] tmo);
        cfg_if.cfg_pattern_i = pat;
        cfg_if.cfg_mask_i    = mask;
        cfg_if.cfg_target_i  = target;
        cfg_if.cfg_tmo_i     = tmo;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check({tag, ":det"},   32'(det_o),              32'd0);
        check({tag, ":cnt"},   32'(match_cnt_o),        32'd0);
        check({tag, ":busy"},  32'(busy_o),             32'd0);
        check({tag, ":done"},  32'(done_o),             32'd0);
        check({tag, ":tmo"},   32'(tmo_o),              32'd0);
        check({tag, ":ready"}, 32'(cfg_if.cfg_ready_o), 32'd1);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [11:0] dpat;
        logic [21:0] stream1;
        int          k;

        dpat    = DEFAULT_PATTERN;
        stream1 = 22'b1110_1101_1011_1011_0110_11;
        cfg_if.cfg_valid_i = 1'b0;
        set_cfg('0, '0, '0, '0);
        model_reset();

        do_reset("reset");

        // Start without any configuration is ignored.
        step(1, 0, 0, 0, 0, "start_nocfg");
        check("start_nocfg_busy", 32'(busy_o), 32'd0);

        // Default pattern, target 2: hits on bits 12 and 22, then DONE.
        set_cfg(DEFAULT_PATTERN, DEFAULT_MASK, 8'd2, 16'd0);
        step(0, 0, 1, 0, 0, "cfg1");
        step(1, 0, 0, 0, 0, "start1");
        for (int i = 1; i <= 22; i++) begin
            step(0, 0, 0, 1, stream1[22-i], "stream1");
            check("stream1_det_pos", 32'(det_o), 32'(i == 12 || i == 22));
        end
        check("stream1_cnt",  32'(match_cnt_o), 32'd2);
        check("stream1_done", 32'(done_o),      32'd1);
        check("stream1_busy", 32'(busy_o),      32'd0);
        step(0, 0, 0, 1, 1, "done_hold");

        // All-zero pattern: every zero from bit 12 onward hits, forever.
        step(0, 1, 0, 0, 0, "abort1");
        set_cfg(12'h000, 12'hFFF, 8'd0, 16'd0);
        step(1, 0, 1, 0, 0, "cfg_start2");
        for (int i = 1; i <= 20; i++) begin
            step(0, 0, 0, 1, 0, "zeros");
            check("zeros_det_pos", 32'(det_o), 32'(i >= 12));
        end

        // Partial mask: only the oldest nibble matters.
        step(0, 1, 0, 0, 0, "abort2");
        set_cfg(12'hE00, 12'hF00, 8'd1, 16'd0);
        step(0, 0, 1, 0, 0, "cfg3");
        step(1, 0, 0, 0, 0, "start3");
        for (int i = 1; i <= 12; i++) begin
            step(0, 0, 0, 1, (i <= 3) ? 1'b1 : (i == 4) ? 1'b0 : 1'($urandom), "mask");
            check("mask_det_pos", 32'(det_o), 32'(i == 12));
        end
        check("mask_done", 32'(done_o), 32'd1);

        // Timeout of 5 valid misses after the window fills; gaps do not count.
        step(0, 1, 0, 0, 0, "abort3");
        set_cfg(DEFAULT_PATTERN, DEFAULT_MASK, 8'd0, 16'd5);
        step(1, 0, 1, 0, 0, "cfg_start4");
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0, "tmo_fill");
        check("tmo_after_fill", 32'(tmo_o), 32'd0);
        for (k = 1; k <= 5; k++) begin
            step(0, 0, 0, 0, 1, "tmo_gap");
            step(0, 0, 0, 1, 0, "tmo_bit");
            check("tmo_level", 32'(tmo_o), 32'(k == 5));
        end

        // Abort wins over a matching bit arriving in the same cycle.
        step(0, 1, 0, 0, 0, "abort4");
        set_cfg(DEFAULT_PATTERN, DEFAULT_MASK, 8'd0, 16'd0);
        step(1, 0, 1, 0, 0, "cfg_start5");
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0, "abort_fill");
        for (int i = 11; i >= 1; i--) step(0, 0, 0, 1, dpat[i], "abort_prefix");
        step(0, 1, 0, 1, dpat[0], "abort_hit");
        check("abort_det",   32'(det_o),              32'd0);
        check("abort_ready", 32'(cfg_if.cfg_ready_o), 32'd1);

        // Randomized traffic with sparse masks so hits, DONE and TIMEOUT all occur.
        for (int i = 0; i < 1500; i++) begin
            set_cfg(12'($urandom), 12'($urandom & $urandom & $urandom),
                    8'($urandom_range(0, 4)), 16'($urandom_range(0, 8)));
            step($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 3) != 0,
                 1'($urandom), "random");
        end

        // Reset in HUNT clears everything, including the loaded config.
        step(0, 1, 0, 0, 0, "abort6");
        set_cfg(DEFAULT_PATTERN, DEFAULT_MASK, 8'd0, 16'd0);
        step(1, 0, 1, 0, 0, "cfg_start7");
        for (int i = 0; i < 14; i++) step(0, 0, 0, 1, 1'($urandom), "hunt7");
        check("hunt7_busy", 32'(busy_o), 32'd1);
        do_reset("reset_mid");
        step(1, 0, 0, 0, 0, "start_after_reset");
        check("start_after_reset_busy", 32'(busy_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
